// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Gated frequency counter for a 10-bit offset-binary waveform (midscale 512).
//   A level detector turns the sample stream into a logic level "hi". Every
//   0->1 transition of hi inside a gate window is counted. At the end of each
//   window the count passes through a two-stage pipeline: latch, then scale to
//   Hz and saturate. The next window starts on the following cycle, so there
//   are no dead cycles between windows.
//
//   Optional feature macro: FREQ_METER_HYST_EN
//     defined   -> hi is set at sample >= 512+HYST and cleared at
//                  sample < 512-HYST; it holds between the two thresholds.
//     undefined -> hi = (sample >= 512) on every qualified sample, and HYST
//                  is ignored.
//
// Parameters
//   GATE_LONG   window length in CLK_fc cycles when gate_sel=0 (result x1)
//   GATE_SHORT  window length in CLK_fc cycles when gate_sel=1 (result x10)
//   HYST        hysteresis half-width in LSB around midscale
//
// Ports
//   CLK_fc        in   sample clock, rising edge
//   RST           in   synchronous active-low reset, has priority over all
//   enable        in   1 = measure continuously, 0 = halt
//   sample[9:0]   in   offset-binary waveform sample
//   sample_valid  in   sample qualifier
//   gate_sel      in   window length select, sampled at each window start
//   f_meas[17:0]  out  measured frequency in Hz (saturates at 262143)
//   f_valid       out  one-cycle pulse when f_meas/overflow update
//   overflow      out  last result was saturated
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int GATE_LONG  = 50_000_000,
  parameter int GATE_SHORT = 5_000_000,
  parameter int HYST       = 16
) (
  input  logic        CLK_fc,
  input  logic        RST,
  input  logic        enable,
  input  logic [9:0]  sample,
  input  logic        sample_valid,
  input  logic        gate_sel,
  output logic [17:0] f_meas,
  output logic        f_valid,
  output logic        overflow
);

  localparam int GMAX = (GATE_LONG > GATE_SHORT) ? GATE_LONG : GATE_SHORT;
  localparam int CW   = $clog2(GMAX) + 1;
  localparam logic [CW-1:0] LONG_LAST  = CW'(GATE_LONG - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(GATE_SHORT - 1);
  localparam logic [CW-1:0] CW_ONE     = CW'(1);
  localparam logic [18:0]   CNT_MAX    = 19'h7FFFF;
  localparam logic [22:0]   F_MAX      = 23'd262143;

`ifdef FREQ_METER_HYST_EN
  localparam int HYS_EFF = HYST;
`else
  // Both thresholds collapse onto midscale, so the comparator below reduces
  // to a plain sample >= 512 test.
  localparam int HYS_EFF = 0 * HYST;
`endif
  localparam logic [10:0] HI_TH = 11'(512 + HYS_EFF);
  localparam logic [10:0] LO_TH = 11'(512 - HYS_EFF);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          hi_r;
  logic          hi_nxt_s;
  logic          rise_s;
  logic [CW-1:0] win_cnt_r;
  logic [18:0]   rise_cnt_r;
  logic [18:0]   rise_sum_s;
  logic          gsel_r;
  logic          last_s;
  logic          s1_valid_r;
  logic [18:0]   s1_cnt_r;
  logic          s1_sel_r;
  logic [22:0]   scaled_s;

  // Level detector: next value of hi from the qualified sample
  always_comb begin
    hi_nxt_s = hi_r;
    if (sample_valid) begin
      if ({1'b0, sample} >= HI_TH) begin
        hi_nxt_s = 1'b1;
      end else if ({1'b0, sample} < LO_TH) begin
        hi_nxt_s = 1'b0;
      end else begin
        hi_nxt_s = hi_r;
      end
    end else begin
      hi_nxt_s = hi_r;
    end
  end

  // A rise is flagged in the cycle whose sample takes hi from 0 to 1
  assign rise_s = hi_nxt_s & ~hi_r;

  // Rise count including this cycle's event, saturating at 19 bits
  assign rise_sum_s = (rise_s && (rise_cnt_r != CNT_MAX)) ? (rise_cnt_r + 19'd1) : rise_cnt_r;

  // Final cycle (N-1) of the running window
  assign last_s = (state_r == GATE) &&
                  (win_cnt_r == (gsel_r ? SHORT_LAST : LONG_LAST));

  // Level state register
  always_ff @(posedge CLK_fc) begin
    if (!RST) begin
      hi_r <= 1'b0;
    end else begin
      hi_r <= hi_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = GATE;
        else        state_nxt_s = IDLE;
      end
      GATE: begin
        if (enable) state_nxt_s = GATE;
        else        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_fc) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window cycle counter, rise counter and per-window gate_sel latch.
  // A window starts on the edge leaving IDLE or on the edge after cycle N-1;
  // gate_sel is captured on that same edge.
  always_ff @(posedge CLK_fc) begin
    if (!RST) begin
      win_cnt_r  <= '0;
      rise_cnt_r <= 19'd0;
      gsel_r     <= 1'b0;
    end else if (!enable) begin
      win_cnt_r  <= '0;
      rise_cnt_r <= 19'd0;
    end else if ((state_r == IDLE) || last_s) begin
      win_cnt_r  <= '0;
      rise_cnt_r <= 19'd0;
      gsel_r     <= gate_sel;
    end else begin
      win_cnt_r  <= win_cnt_r + CW_ONE;
      rise_cnt_r <= rise_sum_s;
    end
  end

  // Stage 1: capture the finished window's count (including a rise on N-1)
  always_ff @(posedge CLK_fc) begin
    if (!RST) begin
      s1_valid_r <= 1'b0;
      s1_cnt_r   <= 19'd0;
      s1_sel_r   <= 1'b0;
    end else if (!enable) begin
      s1_valid_r <= 1'b0;
      s1_cnt_r   <= 19'd0;
      s1_sel_r   <= 1'b0;
    end else if (last_s) begin
      s1_valid_r <= 1'b1;
      s1_cnt_r   <= rise_sum_s;
      s1_sel_r   <= gsel_r;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Scale to Hz: x10 as (c<<3)+(c<<1) for the short gate, x1 for the long gate
  always_comb begin
    scaled_s = {4'd0, s1_cnt_r};
    if (s1_sel_r) begin
      scaled_s = ({4'd0, s1_cnt_r} << 3) + ({4'd0, s1_cnt_r} << 1);
    end else begin
      scaled_s = {4'd0, s1_cnt_r};
    end
  end

  // Stage 2: saturate and publish; outputs hold while halted
  always_ff @(posedge CLK_fc) begin
    if (!RST) begin
      f_meas   <= 18'd0;
      f_valid  <= 1'b0;
      overflow <= 1'b0;
    end else if (enable && s1_valid_r) begin
      f_valid <= 1'b1;
      if (scaled_s > F_MAX) begin
        f_meas   <= 18'h3FFFF;
        overflow <= 1'b1;
      end else begin
        f_meas   <= scaled_s[17:0];
        overflow <= 1'b0;
      end
    end else begin
      f_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//   Scoreboard bench for freq_meter. Stimulus tasks drive random/periodic
//   waveforms and a reference model works out, from window start cycles and
//   counted level rises, what each completed window must report and when.
//   The model pushes those results into a queue, and a monitor pops and
//   compares them on every f_valid. A second instance with one long short-gate
//   window covers the saturation/overflow path.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  localparam int NL  = 1000;
  localparam int NS  = 100;
  localparam int HY  = 16;
  localparam int N2S = 60000;

  logic        CLK_fc = 1'b0;
  logic        RST, enable, sample_valid, gate_sel;
  logic [9:0]  sample;
  logic [17:0] f_meas;
  logic        f_valid, overflow;

  logic        rst2, en2, sv2, gs2;
  logic [9:0]  smp2;
  logic [17:0] f2;
  logic        fv2, ov2;

  always #5 CLK_fc = ~CLK_fc;

  freq_meter #(.GATE_LONG(NL), .GATE_SHORT(NS), .HYST(HY)) dut (
    .CLK_fc(CLK_fc), .RST(RST), .enable(enable), .sample(sample),
    .sample_valid(sample_valid), .gate_sel(gate_sel),
    .f_meas(f_meas), .f_valid(f_valid), .overflow(overflow));

  freq_meter #(.GATE_LONG(8), .GATE_SHORT(N2S), .HYST(HY)) dut2 (
    .CLK_fc(CLK_fc), .RST(rst2), .enable(en2), .sample(smp2),
    .sample_valid(sv2), .gate_sel(gs2),
    .f_meas(f2), .f_valid(fv2), .overflow(ov2));

  typedef struct {
    int f;
    int ov;
    int due;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  int m_hi = 0, m_in = 0, m_ws = 0, m_len = 0, m_sel = 0, m_cnt = 0;
  int obs_f = 0, obs_cyc = -1, last_exp_f = 0;

  // hi after a qualified sample
  function automatic int level(input int hi, input int s);
    int lo_th = 512;
    int hi_th = 512;
`ifdef FREQ_METER_HYST_EN
    lo_th = 512 - HY;
    hi_th = 512 + HY;
`endif
    if (s >= hi_th) return 1;
    if (s < lo_th)  return 0;
    return hi;
  endfunction

  function automatic int sine_s(input logic [29:0] ph);
    return 512 + $rtoi(500.0 * $sin(6.283185307179586 * real'(ph) / 1073741824.0));
  endfunction

  // Expected report for a window that counted cnt rises
  function automatic exp_t result_of(input int cnt, input int sel, input int due);
    exp_t e;
    int c, sc;
    c     = (cnt > 524287) ? 524287 : cnt;
    sc    = (sel != 0) ? c * 10 : c;
    e.f   = (sc > 262143) ? 262143 : sc;
    e.ov  = (sc > 262143) ? 1 : 0;
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic start_window(input logic gs);
    m_ws  = cyc + 1;
    m_sel = gs ? 1 : 0;
    m_len = gs ? NS : NL;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs on the main DUT and advance the model
  task automatic tick(input logic r, input logic en, input logic gs,
                      input int s, input logic sv);
    int nh;
    @(negedge CLK_fc);
    cyc = cyc + 1;
    RST = r; enable = en; gate_sel = gs; sample = 10'(s); sample_valid = sv;
    if (!r) begin
      m_hi = 0;
      m_in = 0;
      if (sb.size() > 0 && sb[$].due == cyc) sb.delete(sb.size() - 1);
    end else begin
      nh = sv ? level(m_hi, s) : m_hi;
      if (m_in != 0 && en && nh == 1 && m_hi == 0) m_cnt++;
      m_hi = nh;
      if (!en) begin
        m_in = 0;
        if (sb.size() > 0 && sb[$].due == cyc) sb.delete(sb.size() - 1);
      end else if (m_in != 0) begin
        if (cyc == m_ws + m_len - 1) begin
          sb.push_back(result_of(m_cnt, m_sel, cyc + 1));
          start_window(gs);
        end
      end else begin
        m_in = 1;
        start_window(gs);
      end
    end
  endtask

  // Monitor: pop and compare on every f_valid, flag overdue results
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_fc);
      #1;
      if (f_valid === 1'b1) begin
        obs_f   = int'(f_meas);
        obs_cyc = cyc;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_f_valid: cycle %0d f_meas %0d, required no output", cyc, f_meas);
        end else begin
          e = sb.pop_front();
          last_exp_f = e.f;
          if (int'(f_meas) != e.f || int'(overflow) != e.ov || cyc != e.due) begin
            bad++;
            $display("FAIL result: got f=%0d ov=%0d cycle=%0d required f=%0d ov=%0d cycle=%0d",
                     f_meas, overflow, cyc, e.f, e.ov, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        e = sb.pop_front();
        $display("FAIL missing_f_valid: got none by cycle %0d required f=%0d at cycle %0d", cyc, e.f, e.due);
      end
    end
  end

  // Overflow instance: one short-gate window of a square wave toggling every cycle
  task automatic run_ovf();
    int   lvl = 0, nl, cnt = 0, ws = 0, end_t = -1, s;
    int   in_win = 0, seen = 0;
    exp_t e;
    e.f = -1; e.ov = -1; e.due = -1;
    rst2 = 1'b0; en2 = 1'b0; gs2 = 1'b1; sv2 = 1'b1; smp2 = 10'd0;
    for (int t = 1; t <= N2S + 10 && seen == 0; t++) begin
      @(negedge CLK_fc);
      if (fv2 === 1'b1) begin
        seen = 1;
        chk("ovf_f_meas", int'(f2), e.f);
        chk("ovf_overflow", int'(ov2), e.ov);
        chk("ovf_timing", t, end_t + 2);
      end
      rst2 = 1'b1; en2 = 1'b1;
      s    = (t % 2 == 1) ? 1023 : 0;
      smp2 = 10'(s);
      nl   = level(lvl, s);
      if (in_win != 0 && nl == 1 && lvl == 0) cnt++;
      lvl = nl;
      if (in_win != 0 && t == ws + N2S - 1) begin
        e      = result_of(cnt, 1, 0);
        end_t  = t;
        in_win = 0;
      end else if (in_win == 0 && end_t < 0) begin
        in_win = 1;
        ws     = t + 1;
      end
    end
    chk("ovf_seen", seen, 1);
  endtask

  task automatic run_main();
    logic [29:0] ph  = 30'd0;
    logic [29:0] inc = 30'd10737418;
    int te;

    // reset
    repeat (3) tick(1'b0, 1'b0, 1'b0, 512, 1'b0);
    @(posedge CLK_fc); #2;
    chk("reset_f_meas", int'(f_meas), 0);
    chk("reset_f_valid", int'(f_valid), 0);
    chk("reset_overflow", int'(overflow), 0);

    // long gate, ~10 periods per window, occasional unqualified samples
    for (int i = 0; i < 3500; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), ($urandom_range(0, 7) != 0));
      ph = ph + inc;
    end
    chk_range("long_gate_f", obs_f, 9, 11);

    // short gate, 12.345 periods per window -> 120 or 130 after x10
    inc = 30'd132553449;
    for (int i = 0; i < 1500; i++) begin
      tick(1'b1, 1'b1, 1'b1, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    total++;
    if (obs_f != 120 && obs_f != 130) begin
      bad++;
      $display("FAIL short_gate_f: got %0d required 120 or 130", obs_f);
    end

    // gate_sel dropped mid-window: running short window keeps x10
    for (int i = 0; i < 37; i++) begin
      tick(1'b1, 1'b1, 1'b1, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    for (int i = 0; i < 1500; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end

    // jitter around midscale
    for (int i = 0; i < 3000; i++) begin
      tick(1'b1, 1'b1, 1'b0, 504 + int'($urandom_range(0, 16)), 1'b1);
    end
`ifdef FREQ_METER_HYST_EN
    chk("jitter_hyst_f", obs_f, 0);
`else
    chk_range("jitter_nohyst_f", obs_f, 1, 262143);
`endif

    // reset at window cycle 500
    inc = 30'd10737418;
    for (int i = 0; i < 2 * NL && (cyc + 1 - m_ws) != 500; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    chk("reset_pos_reached", cyc + 1 - m_ws, 500);
    tick(1'b0, 1'b1, 1'b0, sine_s(ph), 1'b1);
    ph = ph + inc;
    @(posedge CLK_fc); #2;
    chk("midreset_f_meas", int'(f_meas), 0);
    chk("midreset_f_valid", int'(f_valid), 0);
    chk("midreset_overflow", int'(overflow), 0);
    for (int i = 0; i < 1600; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end

    // halt at window cycle 300, outputs hold, then restart
    for (int i = 0; i < 2 * NL && (cyc + 1 - m_ws) != 300; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b0, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    chk("halt_hold_f_meas", int'(f_meas), last_exp_f);
    te = cyc + 1;
    for (int i = 0; i < 1100; i++) begin
      tick(1'b1, 1'b1, 1'b0, sine_s(ph), 1'b1);
      ph = ph + inc;
    end
    chk("restart_first_f_valid_cycle", obs_cyc, te + NL + 1);

    // stop and let any outstanding result drain
    repeat (5) tick(1'b1, 1'b0, 1'b0, 512, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    RST = 1'b0; enable = 1'b0; gate_sel = 1'b0; sample = 10'd512; sample_valid = 1'b0;
    fork
      run_ovf();
      run_main();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
